branch_predictor: RTL and testbench

Parametrised branch prediction and resolution unit for the 5-stage pipelined RISC-V core. Sits beside the IF stage: predicts conditional branches (opcode 1100011) fetched at `if_pc_i`, supplies a predicted next PC to the PC mux, and checks each prediction against the ID-stage branch outcome. On a mispredict it drives the IF/ID flush and a corrected PC, and it trains a table of saturating counters. This replaces the fixed "predict not-taken, resolve in ID" scheme.

---
 rtl/branch_predictor.sv | 151 +++++++++++++++
 tb/tb_branch_predictor.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: conditional-branch prediction and ID-stage resolution.
// Predicts B-type branches in IF (static not-taken, BTFN, or a table of
// saturating counters), raises redirect/flush on an ID-stage mispredict and
// trains the counter table.
// Optional feature macro: BP_STATS_EN adds branch / mispredict counters.
module branch_predictor #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned MODE      = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // fetch-side lookup
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_pc_o,
    // decode-side resolution
    input  logic            id_valid_i,
    input  logic            id_is_branch_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic            id_taken_i,
    input  logic [XLEN-1:0] id_target_i,
    input  logic            id_pred_taken_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o
`ifdef BP_STATS_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
`endif
);

    localparam int unsigned IDX_W      = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam int unsigned SEXT_W     = XLEN - 13;

    // fetch-side decode
    logic            if_is_branch;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] if_seq_pc;
    logic [XLEN-1:0] if_tgt_pc;
    logic            pred_raw;
    logic            cnt_msb;

    // resolve-side decode
    logic            id_resolve;
    logic            mis;
    logic [XLEN-1:0] id_seq_pc;

    // rs1/rs2/funct3 fields are irrelevant to prediction
    logic            unused_instr_bits;
    assign unused_instr_bits = ^if_instr_i[24:12];

    // B-type immediate decode, target and fall-through addresses
    always_comb begin
        if_is_branch = (if_instr_i[6:0] == OPC_BRANCH);
        b_imm        = {{SEXT_W{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                        if_instr_i[30:25], if_instr_i[11:8], 1'b0};
        if_seq_pc    = if_pc_i + XLEN'(4);
        if_tgt_pc    = if_pc_i + b_imm;
    end

    // direction source selected by MODE
    always_comb begin
        pred_raw = 1'b0;
        case (MODE)
            32'd1:   pred_raw = if_instr_i[31];
            32'd2:   pred_raw = cnt_msb;
            default: pred_raw = 1'b0;
        endcase
    end

    // prediction outputs, forced to fall-through while in reset
    always_comb begin
        pred_taken_o = rst_i & if_is_branch & pred_raw;
        pred_pc_o    = pred_taken_o ? if_tgt_pc : if_seq_pc;
    end

    // mispredict detection and corrected PC
    always_comb begin
        id_resolve    = id_valid_i & id_is_branch_i;
        mis           = id_resolve & (id_taken_i != id_pred_taken_i);
        id_seq_pc     = id_pc_i + XLEN'(4);
        redirect_o    = rst_i & mis;
        flush_o       = rst_i & mis;
        redirect_pc_o = id_taken_i ? id_target_i : id_seq_pc;
    end

    generate
        if (MODE == 2) begin : g_bht
            localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
            localparam logic [CNT_W-1:0] CNT_MIN  = {CNT_W{1'b0}};
            localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);

            logic [CNT_W-1:0] bht [BHT_DEPTH];
            logic [IDX_W-1:0] rd_idx;
            logic [IDX_W-1:0] wr_idx;
            logic [CNT_W-1:0] rd_cnt;

            // table indices from word-aligned PC bits; reads see pre-update state
            always_comb begin
                rd_idx  = if_pc_i[IDX_W+1:2];
                wr_idx  = id_pc_i[IDX_W+1:2];
                rd_cnt  = bht[rd_idx];
                cnt_msb = rd_cnt[CNT_W-1];
            end

            // counter table: weakly-not-taken on reset, saturating train on resolve
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                        bht[i] <= CNT_INIT;
                    end
                end else if (id_resolve) begin
                    if (id_taken_i) begin
                        if (bht[wr_idx] != CNT_MAX) begin
                            bht[wr_idx] <= bht[wr_idx] + CNT_W'(1);
                        end
                    end else begin
                        if (bht[wr_idx] != CNT_MIN) begin
                            bht[wr_idx] <= bht[wr_idx] - CNT_W'(1);
                        end
                    end
                end
            end
        end else begin : g_no_bht
            assign cnt_msb = 1'b0;
        end
    endgenerate

`ifdef BP_STATS_EN
    // saturating resolved-branch and mispredict counters
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stat_branches_o <= 32'd0;
            stat_mispred_o  <= 32'd0;
        end else begin
            if (id_resolve && (stat_branches_o != 32'hFFFF_FFFF)) begin
                stat_branches_o <= stat_branches_o + 32'd1;
            end
            if (mis && (stat_mispred_o != 32'hFFFF_FFFF)) begin
                stat_mispred_o <= stat_mispred_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a MODE 2 instance exercises reset,
// training, saturation, mispredict, stall and aliasing; a MODE 1 instance
// covers the BTFN static scheme.
module tb_branch_predictor;

    logic        clk;
    logic        rst_i;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    // MODE 2 instance signals
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        id_valid;
    logic        id_is_branch;
    logic [31:0] id_pc;
    logic        id_taken;
    logic [31:0] id_target;
    logic        id_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;

    // MODE 1 instance signals
    logic        m1_pred_taken;
    logic [31:0] m1_pred_pc;
    logic        m1_valid;
    logic        m1_is_branch;
    logic [31:0] m1_pc;
    logic        m1_taken;
    logic [31:0] m1_target;
    logic        m1_pred_in;
    logic        m1_redirect;
    logic [31:0] m1_redirect_pc;
    logic        m1_flush;

`ifdef BP_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_mis;
    logic [31:0] m1_stat_br;
    logic [31:0] m1_stat_mis;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(2), .MODE(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc),
        .if_instr_i      (if_instr),
        .pred_taken_o    (pred_taken),
        .pred_pc_o       (pred_pc),
        .id_valid_i      (id_valid),
        .id_is_branch_i  (id_is_branch),
        .id_pc_i         (id_pc),
        .id_taken_i      (id_taken),
        .id_target_i     (id_target),
        .id_pred_taken_i (id_pred_taken),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .flush_o         (flush)
`ifdef BP_STATS_EN
        ,
        .stat_branches_o (stat_br),
        .stat_mispred_o  (stat_mis)
`endif
    );

    branch_predictor #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(2), .MODE(1)) dut1 (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc),
        .if_instr_i      (if_instr),
        .pred_taken_o    (m1_pred_taken),
        .pred_pc_o       (m1_pred_pc),
        .id_valid_i      (m1_valid),
        .id_is_branch_i  (m1_is_branch),
        .id_pc_i         (m1_pc),
        .id_taken_i      (m1_taken),
        .id_target_i     (m1_target),
        .id_pred_taken_i (m1_pred_in),
        .redirect_o      (m1_redirect),
        .redirect_pc_o   (m1_redirect_pc),
        .flush_o         (m1_flush)
`ifdef BP_STATS_EN
        ,
        .stat_branches_o (m1_stat_br),
        .stat_mispred_o  (m1_stat_mis)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // beq x0,x0 with a 13-bit signed branch offset
    function automatic logic [31:0] beq(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with a mismatching resolve pending: must be discarded
        rst_i         = 1'b0;
        if_pc         = 32'h100;
        if_instr      = beq(13'h1FF8);
        id_valid      = 1'b1;
        id_is_branch  = 1'b1;
        id_pc         = 32'h40;
        id_taken      = 1'b1;
        id_target     = 32'h50;
        id_pred_taken = 1'b0;
        m1_valid      = 1'b1;
        m1_is_branch  = 1'b1;
        m1_pc         = 32'h100;
        m1_taken      = 1'b1;
        m1_target     = 32'hF8;
        m1_pred_in    = 1'b0;
        repeat (3) edge_step();
        chk("rst_m1_pred_taken", 32'(m1_pred_taken), 32'd0);
        chk("rst_m1_pred_pc",    m1_pred_pc,         32'h104);
        chk("rst_redirect",      32'(redirect),      32'd0);
        chk("rst_flush",         32'(flush),         32'd0);
        chk("rst_m1_redirect",   32'(m1_redirect),   32'd0);

        // leave reset, fetch beq +16 at 0x40: counter 01 -> not taken
        @(negedge clk);
        rst_i    = 1'b1;
        id_valid = 1'b0;
        m1_valid = 1'b0;
        if_pc    = 32'h40;
        if_instr = beq(13'd16);
        #1;
        chk("init_pred_taken", 32'(pred_taken), 32'd0);
        chk("init_pred_pc",    pred_pc,         32'h44);
`ifdef BP_STATS_EN
        chk("init_stat_br",  stat_br,  32'd0);
        chk("init_stat_mis", stat_mis, 32'd0);
`endif

        // train taken at 0x40: 01 -> 10 -> 11 -> 11 -> 11
        @(negedge clk);
        id_valid      = 1'b1;
        id_is_branch  = 1'b1;
        id_pc         = 32'h40;
        id_taken      = 1'b1;
        id_pred_taken = 1'b0;
        edge_step();
        chk("train1_pred_taken", 32'(pred_taken), 32'd1);
        repeat (3) edge_step();
        chk("train4_pred_taken", 32'(pred_taken), 32'd1);
        chk("train4_pred_pc",    pred_pc,         32'h50);

        // not-taken from saturated 11: 10 still taken, then 01 not taken
        id_taken = 1'b0;
        edge_step();
        chk("sat_dec1_pred_taken", 32'(pred_taken), 32'd1);
        edge_step();
        id_valid = 1'b0;
        chk("sat_dec2_pred_taken", 32'(pred_taken), 32'd0);
        chk("sat_dec2_pred_pc",    pred_pc,         32'h44);

        // combinational mispredict cases, never clocked
        @(negedge clk);
        id_valid      = 1'b1;
        id_pc         = 32'h80;
        id_pred_taken = 1'b1;
        id_taken      = 1'b0;
        id_target     = 32'h1000;
        #1;
        chk("mis_nt_redirect",    32'(redirect), 32'd1);
        chk("mis_nt_flush",       32'(flush),    32'd1);
        chk("mis_nt_redirect_pc", redirect_pc,   32'h84);
        id_pred_taken = 1'b0;
        id_taken      = 1'b1;
        id_target     = 32'h20;
        #1;
        chk("mis_t_redirect",    32'(redirect), 32'd1);
        chk("mis_t_redirect_pc", redirect_pc,   32'h20);
        id_pred_taken = 1'b1;
        #1;
        chk("hit_redirect", 32'(redirect), 32'd0);
        chk("hit_flush",    32'(flush),    32'd0);
        id_valid = 1'b0;

        // stall: mismatched branch without valid
        @(negedge clk);
        id_valid      = 1'b0;
        id_is_branch  = 1'b1;
        id_pc         = 32'h40;
        id_taken      = 1'b1;
        id_pred_taken = 1'b0;
        #1;
        chk("stall_redirect", 32'(redirect), 32'd0);
        edge_step();
        chk("stall_pred_taken", 32'(pred_taken), 32'd0);
`ifdef BP_STATS_EN
        chk("stall_stat_br",  stat_br,  32'd6);
        chk("stall_stat_mis", stat_mis, 32'd4);
`endif

        // aliasing: update at 0x004, lookup at 0x104 shares entry 1
        @(negedge clk);
        id_valid      = 1'b1;
        id_pc         = 32'h004;
        id_taken      = 1'b1;
        id_pred_taken = 1'b0;
        edge_step();
        id_valid = 1'b0;
        if_pc    = 32'h104;
        #1;
        chk("alias_pred_taken", 32'(pred_taken), 32'd1);
        chk("alias_pred_pc",    pred_pc,         32'h114);

        // same-cycle update and lookup: pre-update counter (10) is seen
        @(negedge clk);
        id_valid      = 1'b1;
        id_pc         = 32'h004;
        id_taken      = 1'b0;
        id_pred_taken = 1'b1;
        #1;
        chk("same_cycle_pred_taken", 32'(pred_taken), 32'd1);
        edge_step();
        id_valid = 1'b0;
        chk("post_update_pred_taken", 32'(pred_taken), 32'd0);
        chk("post_update_pred_pc",    pred_pc,         32'h108);
`ifdef BP_STATS_EN
        chk("final_stat_br",  stat_br,  32'd8);
        chk("final_stat_mis", stat_mis, 32'd6);
`endif

        // non-branch opcode with sign bit set never predicts taken
        @(negedge clk);
        if_pc    = 32'h40;
        if_instr = 32'h8000_0013;
        #1;
        chk("nonbr_pred_taken",    32'(pred_taken),    32'd0);
        chk("nonbr_m1_pred_taken", 32'(m1_pred_taken), 32'd0);
        chk("nonbr_pred_pc",       pred_pc,            32'h44);
        if_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_pred_pc", pred_pc, 32'h0);

        // MODE 1: backward taken, forward not taken
        if_pc    = 32'h100;
        if_instr = beq(13'h1FF8);
        #1;
        chk("m1_back_pred_taken", 32'(m1_pred_taken), 32'd1);
        chk("m1_back_pred_pc",    m1_pred_pc,         32'hF8);
        if_instr = beq(13'd8);
        #1;
        chk("m1_fwd_pred_taken", 32'(m1_pred_taken), 32'd0);
        chk("m1_fwd_pred_pc",    m1_pred_pc,         32'h104);

        // MODE 1 resolves: two hits and one mispredict
        @(negedge clk);
        m1_valid     = 1'b1;
        m1_is_branch = 1'b1;
        m1_pc        = 32'h200;
        m1_target    = 32'h300;
        m1_taken     = 1'b1;
        m1_pred_in   = 1'b1;
        edge_step();
        m1_taken   = 1'b0;
        m1_pred_in = 1'b0;
        edge_step();
        m1_taken   = 1'b1;
        m1_pred_in = 1'b0;
        #1;
        chk("m1_mis_redirect",    32'(m1_redirect), 32'd1);
        chk("m1_mis_redirect_pc", m1_redirect_pc,   32'h300);
        edge_step();
        m1_valid = 1'b0;
`ifdef BP_STATS_EN
        chk("m1_stat_br",  m1_stat_br,  32'd3);
        chk("m1_stat_mis", m1_stat_mis, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
